// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide memory between fetch (word reads) and data (byte/word loads/stores).
// Serialises each transfer into little-endian byte accesses and answers with a one-cycle ack.
module mem_port_arbiter #(
    parameter bit FIRST_GRANT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic        d_byte,
    input  logic        d_sext,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic [31:0] MMemory_raddr,
    input  logic [7:0]  MMemory_rdata,
    output logic [31:0] MMemory_waddr,
    output logic [7:0]  MMemory_wdata,
    output logic        MMemory_wren,
    output logic        busy,
    output logic        owner
);

    typedef enum logic [1:0] {IDLE, RD, WR, ACK} state_t;

    state_t      state, state_nxt;
    logic [1:0]  cnt;
    logic        lat_byte;
    logic        lat_sext;
    logic [23:0] lat_wdata_hi;
    logic [23:0] result;
    logic        gnt_if, gnt_d, last;
    logic [31:0] rd_word;

    // On a tie the requester that did not own the previous transfer wins.
    always_comb begin
        gnt_d   = d_req & (~if_req | ~owner);
        gnt_if  = if_req & ~gnt_d;
        last    = lat_byte ? (cnt == 2'd0) : (cnt == 2'd3);
        rd_word = lat_byte ? {{24{lat_sext & MMemory_rdata[7]}}, MMemory_rdata}
                           : {MMemory_rdata, result};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (gnt_d && d_we)
                    state_nxt = WR;
                else if (gnt_d || gnt_if)
                    state_nxt = RD;
            end
            RD:      if (last) state_nxt = ACK;
            WR:      if (last) state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= 2'd0;
            lat_byte      <= 1'b0;
            lat_sext      <= 1'b0;
            lat_wdata_hi  <= '0;
            result        <= '0;
            if_rdata      <= '0;
            if_ack        <= 1'b0;
            d_rdata       <= '0;
            d_ack         <= 1'b0;
            MMemory_raddr <= '0;
            MMemory_waddr <= '0;
            MMemory_wdata <= '0;
            MMemory_wren  <= 1'b0;
            owner         <= ~FIRST_GRANT;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_if || gnt_d) begin
                        owner        <= gnt_d;
                        cnt          <= 2'd0;
                        lat_byte     <= gnt_d & d_byte;
                        lat_sext     <= d_sext;
                        lat_wdata_hi <= d_wdata[31:8];
                        if (gnt_d && d_we) begin
                            MMemory_waddr <= d_addr;
                            MMemory_wdata <= d_wdata[7:0];
                            MMemory_wren  <= 1'b1;
                        end else begin
                            MMemory_raddr <= gnt_d ? d_addr : if_addr;
                        end
                    end
                end
                RD: begin
                    MMemory_raddr <= MMemory_raddr + 32'd1;
                    cnt           <= cnt + 2'd1;
                    case (cnt)
                        2'd0:    result[7:0]   <= MMemory_rdata;
                        2'd1:    result[15:8]  <= MMemory_rdata;
                        default: result[23:16] <= MMemory_rdata;
                    endcase
                    if (last) begin
                        if (owner) begin
                            d_rdata <= rd_word;
                            d_ack   <= 1'b1;
                        end else begin
                            if_rdata <= rd_word;
                            if_ack   <= 1'b1;
                        end
                    end
                end
                WR: begin
                    if (last) begin
                        MMemory_wren <= 1'b0;
                        d_ack        <= 1'b1;
                    end else begin
                        MMemory_waddr <= MMemory_waddr + 32'd1;
                        cnt           <= cnt + 2'd1;
                        case (cnt)
                            2'd0:    MMemory_wdata <= lat_wdata_hi[7:0];
                            2'd1:    MMemory_wdata <= lat_wdata_hi[15:8];
                            default: MMemory_wdata <= lat_wdata_hi[23:16];
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: behavioural memory, expected reads/writes queued at issue.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, d_req, d_we, d_byte, d_sext;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [31:0] if_rdata, d_rdata;
    logic        if_ack, d_ack;
    logic [31:0] MMemory_raddr, MMemory_waddr;
    logic [7:0]  MMemory_rdata, MMemory_wdata;
    logic        MMemory_wren, busy, owner;

    logic [7:0]  mem     [0:1023];
    logic [7:0]  ref_mem [0:1023];
    logic [31:0] exp_if[$];
    logic [31:0] exp_d[$];
    logic [39:0] exp_wr[$];
    logic        exp_own[$];
    logic [31:0] d_model;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.FIRST_GRANT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_sext(d_sext),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
        .MMemory_raddr(MMemory_raddr), .MMemory_rdata(MMemory_rdata),
        .MMemory_waddr(MMemory_waddr), .MMemory_wdata(MMemory_wdata),
        .MMemory_wren(MMemory_wren), .busy(busy), .owner(owner)
    );

    assign MMemory_rdata = mem[MMemory_raddr[9:0]];
    always @(posedge clk) if (MMemory_wren) mem[MMemory_waddr[9:0]] <= MMemory_wdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        return ref_mem[a[9:0]];
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return {ref_byte(a + 32'd3), ref_byte(a + 32'd2), ref_byte(a + 32'd1), ref_byte(a)};
    endfunction

    // Output side of the scoreboard.
    always @(negedge clk) begin
        if (if_ack || d_ack) check("ack_exclusive", {63'd0, if_ack & d_ack}, 64'd0);
        if (if_ack) begin
            if (exp_if.size() == 0) check("if_ack_unexpected", 64'd1, 64'd0);
            else check("if_rdata", {32'd0, if_rdata}, {32'd0, exp_if.pop_front()});
        end
        if (d_ack) begin
            if (exp_d.size() == 0) check("d_ack_unexpected", 64'd1, 64'd0);
            else check("d_rdata", {32'd0, d_rdata}, {32'd0, exp_d.pop_front()});
        end
        if (MMemory_wren) begin
            if (exp_wr.size() == 0) check("write_unexpected", 64'd1, 64'd0);
            else check("write", {24'd0, MMemory_waddr, MMemory_wdata}, {24'd0, exp_wr.pop_front()});
        end
    end

    task automatic wait_ack(input bit is_d, output int n, output logic [31:0] ra4);
        bit got = 1'b0;
        n   = 0;
        ra4 = '0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            n++;
            if (n == 4) ra4 = MMemory_raddr;
            if (is_d ? d_ack : if_ack) got = 1'b1;
        end
        if (!got) check("ack_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_fetch(input logic [31:0] addr);
        int n;
        logic [31:0] ra4;
        exp_if.push_back(ref_word(addr));
        @(posedge clk); #2;
        if_req = 1'b1; if_addr = addr;
        wait_ack(1'b0, n, ra4);
        check("if_latency", 64'(n), 64'd5);
        check("if_last_raddr", {32'd0, ra4}, {32'd0, addr + 32'd3});
        check("if_no_d_ack", {63'd0, d_ack}, 64'd0);
        #1 if_req = 1'b0;
    endtask

    task automatic do_data(input bit we, input bit byt, input bit sext,
                           input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        logic [31:0] ra4, v;
        if (we) begin
            for (int k = 0; k < (byt ? 1 : 4); k++) begin
                v = addr + 32'(k);
                exp_wr.push_back({v, wdata[8*k +: 8]});
                ref_mem[v[9:0]] = wdata[8*k +: 8];
            end
        end else begin
            if (byt) d_model = {{24{sext & ref_byte(addr)[7]}}, ref_byte(addr)};
            else     d_model = ref_word(addr);
        end
        exp_d.push_back(d_model);
        @(posedge clk); #2;
        d_req = 1'b1; d_we = we; d_byte = byt; d_sext = sext; d_addr = addr; d_wdata = wdata;
        wait_ack(1'b1, n, ra4);
        check("d_latency", 64'(n), byt ? 64'd2 : 64'd5);
        if (we) check("d_ack_wren_low", {63'd0, MMemory_wren}, 64'd0);
        if (!we && !byt) check("d_last_raddr", {32'd0, ra4}, {32'd0, addr + 32'd3});
        #1 d_req = 1'b0;
    endtask

    initial begin
        int  cnt;
        bit  got;
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 8'(i) ^ 8'h5A;
            ref_mem[i] = 8'(i) ^ 8'h5A;
        end
        mem[10'h100] = 8'h11; mem[10'h101] = 8'h22; mem[10'h102] = 8'h33; mem[10'h103] = 8'h44;
        ref_mem[10'h100] = 8'h11; ref_mem[10'h101] = 8'h22; ref_mem[10'h102] = 8'h33; ref_mem[10'h103] = 8'h44;
        mem[10'h020] = 8'h80; ref_mem[10'h020] = 8'h80;
        d_model = '0;
        rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_byte = 1'b0; d_sext = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        #12;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_owner", {63'd0, owner}, 64'd0);
        check("rst_wren", {63'd0, MMemory_wren}, 64'd0);
        check("rst_acks", {62'd0, if_ack, d_ack}, 64'd0);
        check("rst_rdata", {if_rdata, d_rdata}, 64'd0);
        check("rst_addr", {MMemory_raddr, MMemory_waddr}, 64'd0);
        @(posedge clk); #2 rst_n = 1'b1;

        do_fetch(32'h100);
        check("fetch_word_value", {32'd0, ref_word(32'h100)}, 64'h44332211);
        do_data(1'b0, 1'b1, 1'b1, 32'h20, 32'h0);
        do_data(1'b0, 1'b1, 1'b0, 32'h20, 32'h0);
        do_data(1'b1, 1'b0, 1'b0, 32'h3FE, 32'hA1B2C3D4);
        do_data(1'b1, 1'b1, 1'b0, 32'h30, 32'h000000E7);
        do_data(1'b0, 1'b1, 1'b1, 32'h30, 32'h0);
        do_data(1'b0, 1'b0, 1'b1, 32'hFFFFFFFE, 32'h0);
        do_fetch(32'h3FF);

        // Both requesters held high across reset: data wins first, then strict alternation.
        @(posedge clk); #2;
        rst_n = 1'b0; d_model = '0;
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_byte = 1'b0; d_addr = 32'h40;
        for (int k = 0; k < 2; k++) begin
            exp_if.push_back(ref_word(32'h100));
            exp_d.push_back(ref_word(32'h40));
        end
        d_model = ref_word(32'h40);
        exp_own.push_back(1'b1); exp_own.push_back(1'b0);
        exp_own.push_back(1'b1); exp_own.push_back(1'b0);
        @(posedge clk); #2 rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 60 && cnt < 4; i++) begin
            @(posedge clk); #1;
            if (if_ack || d_ack) begin
                check("grant_order", {63'd0, d_ack}, {63'd0, exp_own.pop_front()});
                check("ack_owner", {63'd0, owner}, {63'd0, d_ack});
                cnt++;
            end
        end
        if (cnt < 4) check("contention_timeout", 64'(cnt), 64'd4);
        #1 if_req = 1'b0; d_req = 1'b0;

        // Reset while the third byte of a word store is on the bus.
        exp_wr.push_back({32'h200, 8'h88});
        exp_wr.push_back({32'h201, 8'h77});
        ref_mem[10'h200] = 8'h88; ref_mem[10'h201] = 8'h77;
        @(posedge clk); #2;
        d_req = 1'b1; d_we = 1'b1; d_byte = 1'b0; d_addr = 32'h200; d_wdata = 32'h55667788;
        cnt = 0;
        for (int i = 0; i < 20 && cnt < 3; i++) begin
            @(posedge clk); #1;
            if (MMemory_wren) cnt++;
        end
        check("midstore_wren_cycles", 64'(cnt), 64'd3);
        #1 rst_n = 1'b0; d_model = '0;
        #1;
        check("midstore_wren", {63'd0, MMemory_wren}, 64'd0);
        check("midstore_busy", {63'd0, busy}, 64'd0);
        check("midstore_ack", {63'd0, d_ack}, 64'd0);
        d_req = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
        got = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (d_ack || if_ack || busy) got = 1'b1;
        end
        check("midstore_quiet", {63'd0, got}, 64'd0);
        do_data(1'b0, 1'b0, 1'b0, 32'h200, 32'h0);
        do_fetch(32'h1FE);

        repeat (3) @(posedge clk);
        check("queues_drained", 64'(exp_if.size() + exp_d.size() + exp_wr.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single byte-wide main memory between two requesters: instruction fetch (word reads only) and the decode/execute unit (byte/word loads and stores).
- Serialises each transfer into byte accesses, little-endian, and assembles or splits 32-bit words.
- Returns one-cycle acknowledges, so the decode FSM no longer sequences memory bytes itself.
- Sits between the fetch unit, the decode unit and the MMemory block.

Parameters:
- FIRST_GRANT, 1, requester that wins the first simultaneous request after reset (0 = fetch, 1 = data).

Ports:
- clk  in  1  system clock, all state changes on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; hold high with if_addr stable until if_ack.
- if_addr  in  32  fetch byte address.
- if_rdata  out  32  fetched word.
- if_ack  out  1  one-cycle pulse; if_rdata valid.
- d_req  in  1  data request; hold high with d_* stable until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_byte  in  1  1 = single byte, 0 = word.
- d_sext  in  1  byte load: 1 = sign-extend, 0 = zero-extend.
- d_addr  in  32  data byte address (no alignment requirement).
- d_wdata  in  32  store data; the byte store uses [7:0].
- d_rdata  out  32  load result.
- d_ack  out  1  one-cycle completion pulse.
- MMemory_raddr  out  32  memory read address.
- MMemory_rdata  in  8  memory read data; valid the cycle after the address is driven, sampled at the next edge.
- MMemory_waddr  out  32  memory write address.
- MMemory_wdata  out  8  memory write data.
- MMemory_wren  out  1  memory write enable.
- busy  out  1  high in any state other than IDLE.
- owner  out  1  requester of the current or last transfer (0 = fetch, 1 = data).

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE, the byte counter to 0, and all outputs to 0.
  - owner = ~FIRST_GRANT, so FIRST_GRANT wins the first tie.
  - Any in-flight transfer is abandoned with no ack; a partial store may leave earlier bytes written.
- States: IDLE, RD, WR, ACK.
- IDLE:
  - Requests are sampled only in IDLE.
  - If exactly one request is high, it is granted.
  - If both are high, the requester that is not owner is granted (round-robin).
  - On grant: latch addr/op/size/sext/wdata, set owner, counter = 0.
  - Fetch grant, or data grant with d_we=0: MMemory_raddr <= addr, go to RD.
  - Data grant with d_we=1: MMemory_waddr <= addr, MMemory_wdata <= wdata[7:0], MMemory_wren <= 1, go to WR.
- RD:
  - Each edge captures MMemory_rdata into result byte [8k+7:8k] and sets MMemory_raddr <= MMemory_raddr+1.
  - The last byte is k=3 for a word, k=0 for a byte; after it, go to ACK.
  - Byte load: result[31:8] = sext ? {24{byte[7]}} : 0.
- WR:
  - Each edge either advances to byte k+1 (MMemory_waddr+1, wdata byte k+1, wren held high) or, after the last byte, sets MMemory_wren <= 0 and goes to ACK.
  - MMemory_wren is high for exactly 4 cycles on a word store and 1 cycle on a byte store.
- ACK:
  - The owner's ack is high for this one cycle; its rdata is updated at entry.
  - d_rdata is not updated for stores.
  - Then go to IDLE.
- rdata outputs hold their value until that requester's next load ack.
- Requester rule: drop req in the cycle after ack. A req still high when IDLE is re-entered is a new request.
- Latency from the grant edge E0 to the ack cycle:
  - word read: ack in the cycle after E4;
  - byte read: after E1;
  - word write: after E4;
  - byte write: after E1.
- Address increments wrap modulo 2^32 (0xFFFFFFFF+1 = 0).
- d_sext is ignored for word loads and stores; d_we and d_byte are not present for fetch.
- MMemory_raddr holds its last value outside RD. MMemory_waddr and MMemory_wdata hold theirs outside WR.

Test Plan:
- Fetch word: memory bytes 0x100..0x103 = 11,22,33,44, if_req with addr 0x100 -> if_ack in the 5th cycle after grant, if_rdata=0x44332211, d_ack stays 0.
- Byte loads: mem[0x20]=0x80, d_req load byte at 0x20 -> d_rdata=0xFFFFFF80 with sext=1 and 0x00000080 with sext=0; ack 1 cycle after grant.
- Word store: addr 0x3FE, wdata 0xA1B2C3D4 -> 4 wren cycles writing 0x3FE:D4, 0x3FF:C3, 0x400:B2, 0x401:A1, then d_ack with wren=0.
- Contention: if_req and d_req held continuously from reset with FIRST_GRANT=1 -> grants alternate data, fetch, data, fetch; each ack goes only to its owner.
- Wrap: word load at 0xFFFFFFFE -> bytes read from FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- Reset mid-store: assert rst_n=0 after the 2nd byte -> wren is 0 immediately, no ack, busy=0; a fresh request after release completes normally.
